// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, baud divisor helper and default parameters
package uart_pkg;

  localparam int DEF_CLK       = 50000000;
  localparam int DEF_BAUD_RATE = 115200;
  localparam int DEF_BITS      = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_state_t;

  function automatic int div(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver serial line input and parallel word/strobe outputs
interface uart_rx_if #(parameter int BITS = 8);

  logic            rx;
  logic [BITS-1:0] data;
  logic            valid;
  logic            frame_err;
  logic            parity_err;
  logic            busy;

  modport master (input rx, output data, valid, frame_err, parity_err, busy);
  modport slave  (output rx, input data, valid, frame_err, parity_err, busy);

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous pins, reset value supplied by the user
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= i_rst_val;
      r_sync <= i_rst_val;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 asynchronous serial receiver with one-cycle valid/error strobes
// Optional even-parity bit between data and stop enabled by UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK       = DEF_CLK,
  parameter int BAUD_RATE = DEF_BAUD_RATE,
  parameter int BITS      = DEF_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_rx_if.master  bus
);

  localparam int DIV  = div(CLK, BAUD_RATE);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;
  localparam int NW   = $clog2(BITS + 1);

  localparam logic [CW-1:0] C_HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] C_DIV_M1   = CW'(DIV - 1);
  localparam logic [NW-1:0] C_LAST_BIT = NW'(BITS - 1);

  uart_state_t     r_state;
  uart_state_t     w_state_nxt;
  logic [CW-1:0]   r_clkd;
  logic [NW-1:0]   r_bitn;
  logic [BITS-1:0] r_shift;
  logic [BITS-1:0] r_data;
  logic [1:0]      r_prime;
  logic            r_armed;
  logic            r_valid;
  logic            r_ferr;
  logic            w_rx_s;
  logic            w_half_tick;
  logic            w_full_tick;
  logic            w_par_bad;
  logic            w_shift_en;
  logic            w_set_valid;
  logic            w_set_ferr;
`ifdef UART_RX_PARITY_EN
  logic            w_set_perr;
  logic            r_par;
  logic            r_perr;
`endif

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rst_val (1'b1),
    .i_d       (bus.rx),
    .o_q       (w_rx_s)
  );

  assign w_half_tick = (r_clkd == C_HALF_M1);
  assign w_full_tick = (r_clkd == C_DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (r_armed && !w_rx_s) w_state_nxt = START;
      START:  if (w_half_tick) w_state_nxt = w_rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (w_full_tick && r_bitn == C_LAST_BIT) w_state_nxt = PARITY;
`else
      DATA:   if (w_full_tick && r_bitn == C_LAST_BIT) w_state_nxt = STOP;
`endif
      PARITY: if (w_full_tick) w_state_nxt = STOP;
      STOP:   if (w_full_tick) w_state_nxt = w_rx_s ? IDLE : BREAK;
      BREAK:  if (w_rx_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stop-bit decision: a low stop bit overrides any parity verdict.
  always_comb begin
    w_shift_en  = (r_state == DATA) && w_full_tick;
    w_set_valid = (r_state == STOP) && w_full_tick && w_rx_s && !w_par_bad;
    w_set_ferr  = (r_state == STOP) && w_full_tick && !w_rx_s;
`ifdef UART_RX_PARITY_EN
    w_set_perr  = (r_state == STOP) && w_full_tick && w_rx_s && w_par_bad;
`endif
  end

  // r_prime masks the synchroniser's reset value so a line held low
  // through reset is never mistaken for an idle-high line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clkd  <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_prime <= '0;
      r_armed <= 1'b0;
    end else begin
      r_prime <= {r_prime[0], 1'b1};
      if (w_rx_s && r_prime[1]) r_armed <= 1'b1;
      if (r_state == IDLE || r_state == BREAK || w_state_nxt != r_state || w_full_tick)
        r_clkd <= '0;
      else
        r_clkd <= r_clkd + 1'b1;
      if (r_state != DATA) r_bitn <= '0;
      else if (w_shift_en) r_bitn <= r_bitn + 1'b1;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_set_valid;
      r_ferr  <= w_set_ferr;
      if (w_set_valid) r_data <= r_shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (r_state == PARITY && w_full_tick) r_par <= w_rx_s;
      r_perr <= w_set_perr;
    end
  end

  assign w_par_bad      = (^r_shift) != r_par;
  assign bus.parity_err = r_perr;
`else
  assign w_par_bad      = 1'b0;
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench: directed frames at 115200 and a +3% loopback sweep
// UART_RX_PARITY_EN adds the even-parity bit to every frame and a corrupted-parity case.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DIV_A   = div(DEF_CLK, DEF_BAUD_RATE);
  localparam int BAUD_B  = 3125000;
  localparam int BIT_B_T = 310;  // 16 clocks of 20 units, shortened ~3%

  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;
`ifdef UART_RX_PARITY_EN
  logic flip_par = 1'b0;
`endif

  uart_rx_if #(.BITS(8)) if_a ();
  uart_rx_if #(.BITS(8)) if_b ();

  uart_rx #(.CLK(DEF_CLK), .BAUD_RATE(DEF_BAUD_RATE), .BITS(8)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(if_a)
  );
  uart_rx #(.CLK(DEF_CLK), .BAUD_RATE(BAUD_B), .BITS(8)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(if_b)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [2:0] k, input logic [7:0] d);
    q_a.push_back('{kind: k, data: d});
  endtask

  task automatic push_b(input logic [2:0] k, input logic [7:0] d);
    q_b.push_back('{kind: k, data: d});
  endtask

  task automatic drive_bit_a(input logic v);
    if_a.rx = v;
    repeat (DIV_A) @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] b, input logic stop_bit);
    drive_bit_a(1'b0);
    for (int i = 0; i < 8; i++) drive_bit_a(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit_a((^b) ^ flip_par);
`endif
    drive_bit_a(stop_bit);
  endtask

  task automatic send_b(input logic [7:0] b);
    if_b.rx = 1'b0;
    #BIT_B_T;
    for (int i = 0; i < 8; i++) begin
      if_b.rx = b[i];
      #BIT_B_T;
    end
`ifdef UART_RX_PARITY_EN
    if_b.rx = ^b;
    #BIT_B_T;
`endif
    if_b.rx = 1'b1;
    #BIT_B_T;
  endtask

  always @(negedge clk) begin
    if (if_a.valid || if_a.frame_err || if_a.parity_err) begin
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_strobe: got strobes %b data 0x%0h, required none",
                 {if_a.parity_err, if_a.frame_err, if_a.valid}, if_a.data);
      end else begin
        e_a = q_a.pop_front();
        check("a_strobe_kind", {29'd0, if_a.parity_err, if_a.frame_err, if_a.valid}, {29'd0, e_a.kind});
        check("a_data", {24'd0, if_a.data}, {24'd0, e_a.data});
        if (e_a.kind == K_VALID) check("a_busy_with_valid", {31'd0, if_a.busy}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (if_b.valid || if_b.frame_err || if_b.parity_err) begin
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_strobe: got strobes %b data 0x%0h, required none",
                 {if_b.parity_err, if_b.frame_err, if_b.valid}, if_b.data);
      end else begin
        e_b = q_b.pop_front();
        check("b_strobe_kind", {29'd0, if_b.parity_err, if_b.frame_err, if_b.valid}, {29'd0, e_b.kind});
        check("b_data", {24'd0, if_b.data}, {24'd0, e_b.data});
      end
    end
  end

  task automatic flow_a();
    // Line held low through and after reset: no start bit may be taken.
    repeat (1000) @(negedge clk);
    check("a_low_at_reset_busy", {31'd0, if_a.busy}, 32'd0);
    if_a.rx = 1'b1;
    repeat (50) @(negedge clk);

    push_a(K_VALID, 8'h55);
    send_a(8'h55, 1'b1);
    repeat (100) @(negedge clk);

    push_a(K_VALID, 8'hA5);
    push_a(K_VALID, 8'h3C);
    send_a(8'hA5, 1'b1);
    send_a(8'h3C, 1'b1);
    repeat (50) @(negedge clk);

    if_a.rx = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch_busy_high", {31'd0, if_a.busy}, 32'd1);
    repeat (50) @(negedge clk);
    if_a.rx = 1'b1;
    for (int i = 0; i < 220 && if_a.busy; i++) @(negedge clk);
    check("glitch_busy_low", {31'd0, if_a.busy}, 32'd0);
    repeat (500) @(negedge clk);

    push_a(K_FERR, 8'h3C);
    send_a(8'h81, 1'b0);
    if_a.rx = 1'b1;
    repeat (2 * DIV_A) @(negedge clk);
    check("ferr_busy_after_break", {31'd0, if_a.busy}, 32'd0);
    push_a(K_VALID, 8'h42);
    send_a(8'h42, 1'b1);
    repeat (50) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    flip_par = 1'b1;
    push_a(K_PERR, 8'h42);
    send_a(8'h99, 1'b1);
    flip_par = 1'b0;
    repeat (50) @(negedge clk);
`endif

    fork
      send_a(8'h00, 1'b1);
      begin
        repeat (4 * DIV_A + DIV_A / 2) @(negedge clk);
        rst_a_n = 1'b0;
        @(negedge clk);
        check("a_rst_mid_data", {24'd0, if_a.data}, 32'd0);
        check("a_rst_mid_busy", {31'd0, if_a.busy}, 32'd0);
        check("a_rst_mid_valid", {31'd0, if_a.valid}, 32'd0);
      end
    join
    rst_a_n = 1'b1;
    repeat (20) @(negedge clk);
    push_a(K_VALID, 8'h7E);
    send_a(8'h7E, 1'b1);
    repeat (50) @(negedge clk);
  endtask

  task automatic flow_b();
    logic [7:0] b;
    repeat (20) @(negedge clk);
    #3;
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      push_b(K_VALID, b);
      send_b(b);
    end
    repeat (50) @(negedge clk);
  endtask

  initial begin
    if_a.rx = 1'b0;
    if_b.rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, if_a.data}, 32'd0);
    check("rst_valid", {31'd0, if_a.valid}, 32'd0);
    check("rst_frame_err", {31'd0, if_a.frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, if_a.parity_err}, 32'd0);
    check("rst_busy", {31'd0, if_a.busy}, 32'd0);
    check("rst_b_busy", {31'd0, if_b.busy}, 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    fork
      flow_a();
      flow_b();
    join
    repeat (20) @(negedge clk);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1900000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $fatal(1);
  end

endmodule
